// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: funct3 encodings, FSM state constants and size decode helpers
// shared by the load/store unit and its lane-alignment sub-module.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} lsu_size_e;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t S_IDLE  = 2'd0;
  localparam lsu_state_t S_BEAT0 = 2'd1;
  localparam lsu_state_t S_BEAT1 = 2'd2;
  localparam lsu_state_t S_FIN   = 2'd3;

  // Access size in bytes from funct3[1:0].
  function automatic logic [3:0] size_bytes(input lsu_size_e sz);
    return 4'(1) << sz;
  endfunction

  // Sizes the datapath cannot perform: doubleword on a 32-bit core, the
  // reserved 111 encoding, and "unsigned" stores.
  function automatic logic size_illegal(input logic [2:0] f3, input logic st,
                                        input int unsigned xlen);
    return (f3 == 3'b111) || ((f3[1:0] == 2'b11) && (xlen == 32)) || (st && f3[2]);
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: req/ack data-memory bus between the LSU (master) and memory (slave).
interface riscv_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NB-1:0]     mem_be;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_err;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_ack, mem_rdata, mem_err);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_ack, mem_rdata, mem_err);
endinterface

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte-lane steering. Produces the byte-enable mask and the
// lane-shifted store word for one beat (hi selects the second beat of a split
// access), and the shifted, size-masked, sign/zero-extended load value from a
// two-word read window.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int LW   = $clog2(NB)
) (
  input  logic [LW-1:0]     lane,
  input  logic [1:0]        sz,
  input  logic              uns,
  input  logic              hi,
  input  logic [XLEN-1:0]   sdata,
  input  logic [2*XLEN-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ldata
);

  logic [2*NB-1:0]   mask2;
  logic [2*XLEN-1:0] wide_w;
  logic [2*XLEN-1:0] wide_r;
  logic [XLEN-1:0]   lowmask;
  logic [6:0]        nbits;
  logic              sgn;

  // Masks/shifts are built over a double-width window; the upper half is what
  // spills into the next word on a split access.
  always_comb begin
    mask2   = ((2*NB)'(1) << size_bytes(lsu_size_e'(sz))) - (2*NB)'(1);
    mask2   = mask2 << lane;
    be      = hi ? mask2[2*NB-1:NB] : mask2[NB-1:0];
    wide_w  = {{XLEN{1'b0}}, sdata} << {lane, 3'b000};
    wdata   = hi ? wide_w[2*XLEN-1:XLEN] : wide_w[XLEN-1:0];
    wide_r  = rdata >> {lane, 3'b000};
    nbits   = 7'(size_bytes(lsu_size_e'(sz))) << 3;
    lowmask = (int'(nbits) >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    sgn     = wide_r[7'(nbits - 7'd1)];
    ldata   = wide_r[XLEN-1:0] & lowmask;
    if (!uns && sgn) ldata = ldata | ~lowmask;
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit with a req/ack memory handshake.
// Optional feature macro RISCV_LSU_MISALIGN_EN: when defined, misaligned
// accesses are performed (split into two beats when crossing a word) instead
// of raising fault_misaligned.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  base,
  input  logic [11:0]      offset,
  input  logic [XLEN-1:0]  store_data,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  load_data,
  output logic             rd_wen,
  output logic             fault_misaligned,
  output logic             fault_illegal,
  output logic             fault_bus,
  riscv_lsu_if.master      mem
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [2:0]        f3_q, f3_d;
  logic              st_q, st_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic              split_q, split_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              fm_pend_q, fm_pend_d, fi_pend_q, fi_pend_d, fb_pend_q, fb_pend_d;
  logic              done_q, done_d, rd_wen_q, rd_wen_d;
  logic              fm_q, fm_d, fi_q, fi_d, fb_q, fb_d;

  logic [XLEN-1:0]   sum;
  logic [ADDR_W-1:0] ea, addr0;
  logic [LW-1:0]     lane_in;
  logic [3:0]        bytes_in;
  logic              illegal, mis_fault, split_in, in_beat;
  logic [NB-1:0]     enc_be, ext_be_nc;
  logic [XLEN-1:0]   enc_wdata, enc_ldata_nc, ext_wdata_nc, ext_data;
  logic [2*XLEN-1:0] rwin;

  // Request decode on the live core inputs; only used in IDLE.
  always_comb begin
    sum      = base + XLEN'($signed(offset));
    ea       = ADDR_W'(sum);
    lane_in  = ea[LW-1:0];
    bytes_in = size_bytes(lsu_size_e'(funct3[1:0]));
    illegal  = size_illegal(funct3, is_store, XLEN);
`ifdef RISCV_LSU_MISALIGN_EN
    mis_fault = 1'b0;
    split_in  = (int'(lane_in) + int'(bytes_in)) > NB;
`else
    mis_fault = (ea[3:0] & (bytes_in - 4'd1)) != 4'd0;
    split_in  = 1'b0;
`endif
  end

  assign in_beat = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign addr0   = {ea_q[ADDR_W-1:LW], {LW{1'b0}}};
  assign rwin    = split_q ? {mem.mem_rdata, rdata0_q} : {{XLEN{1'b0}}, mem.mem_rdata};

  riscv_lsu_align #(.XLEN(XLEN)) u_enc (
    .lane  (ea_q[LW-1:0]),
    .sz    (f3_q[1:0]),
    .uns   (f3_q[2]),
    .hi    (state_q == S_BEAT1),
    .sdata (sdata_q),
    .rdata ({(2*XLEN){1'b0}}),
    .be    (enc_be),
    .wdata (enc_wdata),
    .ldata (enc_ldata_nc)
  );

  riscv_lsu_align #(.XLEN(XLEN)) u_ext (
    .lane  (ea_q[LW-1:0]),
    .sz    (f3_q[1:0]),
    .uns   (f3_q[2]),
    .hi    (1'b0),
    .sdata ({XLEN{1'b0}}),
    .rdata (rwin),
    .be    (ext_be_nc),
    .wdata (ext_wdata_nc),
    .ldata (ext_data)
  );

  // Bus outputs come straight from registered state, so they are stable for
  // the whole beat and drop the moment reset clears the FSM.
  assign mem.mem_req   = in_beat;
  assign mem.mem_we    = in_beat && st_q;
  assign mem.mem_addr  = !in_beat ? '0 : (state_q == S_BEAT1) ? addr0 + ADDR_W'(NB) : addr0;
  assign mem.mem_be    = in_beat ? enc_be : '0;
  assign mem.mem_wdata = in_beat ? enc_wdata : '0;

  assign busy             = state_q != S_IDLE;
  assign done             = done_q;
  assign rd_wen           = rd_wen_q;
  assign load_data        = load_data_q;
  assign fault_misaligned = fm_q;
  assign fault_illegal    = fi_q;
  assign fault_bus        = fb_q;

  // FSM next state, request capture, beat sequencing and completion pulses.
  always_comb begin
    state_d     = state_q;
    ea_d        = ea_q;
    f3_d        = f3_q;
    st_d        = st_q;
    sdata_d     = sdata_q;
    split_d     = split_q;
    rdata0_d    = rdata0_q;
    load_data_d = load_data_q;
    fm_pend_d   = fm_pend_q;
    fi_pend_d   = fi_pend_q;
    fb_pend_d   = fb_pend_q;
    case (state_q)
      S_IDLE: if (start && en) begin
        ea_d      = ea;
        f3_d      = funct3;
        st_d      = is_store;
        sdata_d   = store_data;
        split_d   = split_in;
        fi_pend_d = illegal;
        fm_pend_d = !illegal && mis_fault;
        fb_pend_d = 1'b0;
        state_d   = (illegal || mis_fault) ? S_FIN : S_BEAT0;
      end
      S_BEAT0: if (mem.mem_ack) begin
        if (mem.mem_err) begin
          fb_pend_d = 1'b1;
          state_d   = S_FIN;
        end else if (split_q) begin
          rdata0_d = mem.mem_rdata;
          state_d  = S_BEAT1;
        end else begin
          if (!st_q) load_data_d = ext_data;
          state_d = S_FIN;
        end
      end
      S_BEAT1: if (mem.mem_ack) begin
        if (mem.mem_err) fb_pend_d = 1'b1;
        else if (!st_q) load_data_d = ext_data;
        state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
    done_d   = state_q == S_FIN;
    rd_wen_d = (state_q == S_FIN) && !st_q && !(fi_pend_q || fm_pend_q || fb_pend_q);
    fm_d     = (state_q == S_FIN) && fm_pend_q;
    fi_d     = (state_q == S_FIN) && fi_pend_q;
    fb_d     = (state_q == S_FIN) && fb_pend_q;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ea_q        <= '0;
      f3_q        <= '0;
      st_q        <= 1'b0;
      sdata_q     <= '0;
      split_q     <= 1'b0;
      rdata0_q    <= '0;
      load_data_q <= '0;
      fm_pend_q   <= 1'b0;
      fi_pend_q   <= 1'b0;
      fb_pend_q   <= 1'b0;
      done_q      <= 1'b0;
      rd_wen_q    <= 1'b0;
      fm_q        <= 1'b0;
      fi_q        <= 1'b0;
      fb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ea_q        <= ea_d;
      f3_q        <= f3_d;
      st_q        <= st_d;
      sdata_q     <= sdata_d;
      split_q     <= split_d;
      rdata0_q    <= rdata0_d;
      load_data_q <= load_data_d;
      fm_pend_q   <= fm_pend_d;
      fi_pend_q   <= fi_pend_d;
      fb_pend_q   <= fb_pend_d;
      done_q      <= done_d;
      rd_wen_q    <= rd_wen_d;
      fm_q        <= fm_d;
      fi_q        <= fi_d;
      fb_q        <= fb_d;
    end
  end

endmodule
